// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter and the ALU_top datapath.
//   - ALUOp encodings
//   - bit positions of N/V/C/Z inside the 4-bit flags word
//   - arbiter FSM state encoding
//   - helper that packs individual flag bits into the flags word
package alu_pkg;

  localparam int unsigned ALU_W = 32;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;
  localparam logic [1:0] ALU_SUB = 2'b11;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_Z = 0;

  typedef logic [1:0] alu_state_t;
  localparam alu_state_t IDLE = 2'd0;
  localparam alu_state_t EXEC = 2'd1;
  localparam alu_state_t RESP = 2'd2;

  function automatic logic [3:0] pack_flags(input logic n, input logic v, input logic c,
                                            input logic z);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_V] = v;
    f[FLAG_C] = c;
    f[FLAG_Z] = z;
    return f;
  endfunction

endpackage

// File: rtl/ALU_top.sv
// Shared 32-bit ALU datapath (purely combinational).
// Ports:
//   a_i, b_i    operands
//   alu_op_i    00 AND, 01 OR, 10 ADD, 11 SUB (A + ~B + 1)
//   result_o    ALU result
//   n_o/v_o/c_o/z_o  negative, signed overflow, carry (no-borrow for SUB), zero
module ALU_top
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] a_i,
  input  logic [ALU_W-1:0] b_i,
  input  logic [1:0]       alu_op_i,
  output logic [ALU_W-1:0] result_o,
  output logic             n_o,
  output logic             v_o,
  output logic             c_o,
  output logic             z_o
);

  logic [ALU_W-1:0] b_eff;
  logic [ALU_W:0]   sum;
  logic             is_sub;
  logic             is_arith;

  always_comb begin
    is_sub   = (alu_op_i == ALU_SUB);
    is_arith = (alu_op_i == ALU_ADD) || is_sub;
    b_eff    = is_sub ? ~b_i : b_i;
    // The +1 of two's-complement subtraction enters as the carry-in.
    sum      = {1'b0, a_i} + {1'b0, b_eff} + {{ALU_W{1'b0}}, is_sub};
  end

  always_comb begin
    result_o = '0;
    unique case (alu_op_i)
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_ADD: result_o = sum[ALU_W-1:0];
      ALU_SUB: result_o = sum[ALU_W-1:0];
      default: result_o = '0;
    endcase
  end

  always_comb begin
    n_o = result_o[ALU_W-1];
    z_o = (result_o == '0);
    c_o = is_arith & sum[ALU_W];
    // Overflow: both effective operands share a sign that the sum does not.
    v_o = is_arith & (a_i[ALU_W-1] == b_eff[ALU_W-1]) & (sum[ALU_W-1] != a_i[ALU_W-1]);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of one shared ALU_top.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   reqN_valid/ready               request handshake per requester (N = 0, 1)
//   reqN_a, reqN_b, reqN_op        operands and ALUOp
//   rspN_valid/ready               response handshake per requester
//   rspN_result, rspN_flags        result and {N,V,C,Z}, zero unless rspN_valid
// Sequence per op: IDLE (grant) -> EXEC (ALU runs on latched operands) -> RESP (hold).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter logic        RR_RESET = 1'b0
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [1:0]        req0_op,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [1:0]        req1_op,

  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic [3:0]        rsp0_flags,

  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic [3:0]        rsp1_flags
);

  alu_state_t        state_q, state_d;
  logic              prio_q, prio_d;
  logic              gid_q, gid_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [1:0]        op_q, op_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [3:0]        flags_q, flags_d;

  logic [DATA_W-1:0] alu_result;
  logic              alu_n, alu_v, alu_c, alu_z;

  logic              in_idle;
  logic              acc0, acc1;
  logic              rsp_done;

  ALU_top u_alu (
    .a_i      (a_q),
    .b_i      (b_q),
    .alu_op_i (op_q),
    .result_o (alu_result),
    .n_o      (alu_n),
    .v_o      (alu_v),
    .c_o      (alu_c),
    .z_o      (alu_z)
  );

  // A port's ready looks only at the other port's valid, so a requester can never
  // create a combinational loop through its own valid.
  always_comb begin
    in_idle    = (state_q == IDLE);
    req0_ready = in_idle & (~req1_valid | ~prio_q);
    req1_ready = in_idle & (~req0_valid |  prio_q);
    acc0       = req0_valid & req0_ready;
    acc1       = req1_valid & req1_ready;
    rsp_done   = gid_q ? rsp1_ready : rsp0_ready;
  end

  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    gid_d    = gid_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      IDLE: begin
        if (acc0) begin
          a_d     = req0_a;
          b_d     = req0_b;
          op_d    = req0_op;
          gid_d   = 1'b0;
          state_d = EXEC;
        end else if (acc1) begin
          a_d     = req1_a;
          b_d     = req1_b;
          op_d    = req1_op;
          gid_d   = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_result;
        flags_d  = pack_flags(alu_n, alu_v, alu_c, alu_z);
        state_d  = RESP;
      end
      RESP: begin
        // Priority moves only when a response completes.
        if (rsp_done) begin
          prio_d  = ~gid_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      prio_q   <= RR_RESET;
      gid_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      gid_q    <= gid_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  always_comb begin
    rsp0_valid  = (state_q == RESP) & ~gid_q;
    rsp1_valid  = (state_q == RESP) &  gid_q;
    rsp0_result = rsp0_valid ? result_q : '0;
    rsp0_flags  = rsp0_valid ? flags_q  : '0;
    rsp1_result = rsp1_valid ? result_q : '0;
    rsp1_flags  = rsp1_valid ? flags_q  : '0;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed cases followed by a randomized
// two-port regression against an arithmetic reference model and per-port queues.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam logic RR = 1'b0;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [1:0]  req0_op = '0, req1_op = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [31:0] rsp0_result, rsp1_result;
  logic [3:0]  rsp0_flags, rsp1_flags;

  int total = 0;
  int bad   = 0;

  alu_arbiter #(.DATA_W(32), .RR_RESET(RR)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_op     (req0_op),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_op     (req1_op),
    .rsp0_valid  (rsp0_valid),
    .rsp0_ready  (rsp0_ready),
    .rsp0_result (rsp0_result),
    .rsp0_flags  (rsp0_flags),
    .rsp1_valid  (rsp1_valid),
    .rsp1_ready  (rsp1_ready),
    .rsp1_result (rsp1_result),
    .rsp1_flags  (rsp1_flags)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: result from plain operators, C as unsigned carry / no-borrow,
  // V as "true signed result does not fit in 32 bits".
  function automatic logic [35:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
    logic [31:0] r;
    logic        v, c;
    longint      s;
    v = 1'b0;
    c = 1'b0;
    r = '0;
    case (op)
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_ADD: begin
        r = a + b;
        c = (64'(a) + 64'(b)) > 64'h0000_0000_FFFF_FFFF;
        s = longint'($signed(a)) + longint'($signed(b));
        v = (s > SMAX) || (s < SMIN);
      end
      default: begin
        r = a - b;
        c = (a >= b);
        s = longint'($signed(a)) - longint'($signed(b));
        v = (s > SMAX) || (s < SMIN);
      end
    endcase
    return {r, r[31], v, c, (r == 32'd0)};
  endfunction

  function automatic logic rdy(input logic p);
    return p ? req1_ready : req0_ready;
  endfunction

  function automatic logic rvalid(input logic p);
    return p ? rsp1_valid : rsp0_valid;
  endfunction

  function automatic logic [35:0] rdata(input logic p);
    return p ? {rsp1_result, rsp1_flags} : {rsp0_result, rsp0_flags};
  endfunction

  task automatic set_req(input logic p, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] op);
    if (p) begin
      req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge with the request presented; returns at the negedge
  // right after the accepting posedge.
  task automatic wait_accept(input logic p, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (rdy(p)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check_eq("accept_timeout", 64'(0), 64'(1));
    else @(negedge clk);
  endtask

  task automatic directed_op(input string tag, input logic p, input logic [31:0] a,
                             input logic [31:0] b, input logic [1:0] op,
                             input logic [31:0] exp_r, input logic [3:0] exp_f);
    logic ok;
    @(negedge clk);
    set_req(p, 1'b1, a, b, op);
    wait_accept(p, ok);
    set_req(p, 1'b0, a, b, op);
    if (ok) begin
      #1 check_eq({tag, "_exec_novalid"}, 64'(rvalid(p)), 64'(0));
      @(negedge clk);
      #1;
      check_eq({tag, "_valid"}, 64'(rvalid(p)), 64'(1));
      check_eq({tag, "_other_idle"}, 64'(rvalid(~p)), 64'(0));
      check_eq({tag, "_data"}, 64'(rdata(p)), 64'({exp_r, exp_f}));
      @(negedge clk);
      #1 check_eq({tag, "_consumed"}, 64'(rvalid(p)), 64'(0));
    end
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] corner [4];
    corner[0] = 32'h0000_0000;
    corner[1] = 32'hFFFF_FFFF;
    corner[2] = 32'h8000_0000;
    corner[3] = 32'h7FFF_FFFF;
    if ($urandom_range(3, 0) == 0) return corner[2'($urandom_range(3, 0))];
    return $urandom;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ok;
    logic        gnt;
    logic        prio_m;
    logic        v [2];
    logic [31:0] pa [2];
    logic [31:0] pb [2];
    logic [1:0]  pop [2];
    int          issued [2];
    logic [35:0] q0 [$];
    logic [35:0] q1 [$];
    logic [35:0] e;
    int          done;
    int          cyc;

    // Reset state, with reset still asserted
    #2;
    check_eq("rst_rsp_valid", 64'({rsp0_valid, rsp1_valid}), 64'(0));
    check_eq("rst_rsp_data", 64'({rsp0_result, rsp0_flags, rsp1_flags}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    req0_valid = 1'b1;
    #1 check_eq("rst_ready_immediate", 64'({req0_ready, rsp0_valid}), 64'(2'b10));
    req0_valid = 1'b0;

    // Directed single ops
    directed_op("add_ovf", 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, ALU_ADD, 32'h8000_0000, 4'b1100);
    directed_op("sub_pos", 1'b1, 32'h0000_0003, 32'h0000_0002, ALU_SUB, 32'h0000_0001, 4'b0010);
    directed_op("sub_neg", 1'b1, 32'h0000_0000, 32'h0000_0001, ALU_SUB, 32'hFFFF_FFFF, 4'b1000);

    // Both valid continuously: grants alternate starting at RR
    do_reset();
    set_req(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0F0F_0F0F, ALU_AND);
    set_req(1'b1, 1'b1, 32'h8000_0000, 32'h0000_0001, ALU_OR);
    for (int g = 0; g < 4; g++) begin
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        #1;
        if (req0_ready || req1_ready) begin
          ok = 1'b1;
          break;
        end
        @(negedge clk);
      end
      if (!ok) begin
        check_eq("alt_timeout", 64'(0), 64'(1));
        break;
      end
      gnt = req1_ready;
      check_eq("alt_grant", 64'(gnt), 64'(g % 2 == 1));
      @(negedge clk);
      @(negedge clk);
      #1;
      if (g % 2 == 0) check_eq("alt_rsp0", 64'({rsp0_valid, rdata(1'b0)}), 64'({1'b1, 32'h0F0F_0F0F, 4'b0000}));
      else check_eq("alt_rsp1", 64'({rsp1_valid, rdata(1'b1)}), 64'({1'b1, 32'h8000_0001, 4'b1000}));
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Back-pressure on port 0
    do_reset();
    rsp0_ready = 1'b0;
    set_req(1'b0, 1'b1, 32'h0, 32'h0, ALU_AND);
    wait_accept(1'b0, ok);
    set_req(1'b0, 1'b1, 32'h1, 32'h1, ALU_ADD);
    set_req(1'b1, 1'b1, 32'h1, 32'h2, ALU_OR);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("bp_hold", 64'({rsp0_valid, rsp0_result, rsp0_flags}), 64'({1'b1, 32'h0, 4'b0001}));
      check_eq("bp_ready_low", 64'({req0_ready, req1_ready}), 64'(0));
      @(negedge clk);
    end
    rsp0_ready = 1'b1;
    @(negedge clk);
    #1 check_eq("bp_prio_flip", 64'({req0_ready, req1_ready}), 64'(2'b01));
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Reset during EXEC drops the op and restores RR priority
    do_reset();
    directed_op("pre_rst", 1'b0, 32'h1, 32'h1, ALU_ADD, 32'h2, 4'b0000);
    @(negedge clk);
    set_req(1'b1, 1'b1, 32'h5, 32'h3, ALU_SUB);
    wait_accept(1'b1, ok);
    req1_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("midrst_valid", 64'({rsp0_valid, rsp1_valid}), 64'(0));
    check_eq("midrst_data", 64'({rsp1_result, rsp1_flags, rsp0_flags}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 check_eq("midrst_no_rsp", 64'({rsp0_valid, rsp1_valid}), 64'(0));
      @(negedge clk);
    end
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1 check_eq("midrst_prio", 64'({req0_ready, req1_ready}), RR ? 64'(2'b01) : 64'(2'b10));
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Randomized regression
    do_reset();
    prio_m = RR;
    for (int p = 0; p < 2; p++) begin
      v[p] = 1'b0; pa[p] = '0; pb[p] = '0; pop[p] = '0; issued[p] = 0;
    end
    done = 0;
    cyc  = 0;
    while (done < 1000 && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      for (int p = 0; p < 2; p++) begin
        if (!v[p] && issued[p] < 500 && $urandom_range(1, 0) == 1) begin
          v[p]   = 1'b1;
          pa[p]  = pick_operand();
          pb[p]  = pick_operand();
          pop[p] = 2'($urandom_range(3, 0));
          issued[p]++;
        end
      end
      set_req(1'b0, v[0], pa[0], pb[0], pop[0]);
      set_req(1'b1, v[1], pa[1], pb[1], pop[1]);
      rsp0_ready = ($urandom_range(3, 0) != 0);
      rsp1_ready = ($urandom_range(3, 0) != 0);
      #1;
      if (rsp0_valid && rsp1_valid) check_eq("rand_one_rsp", 64'(1), 64'(0));
      if (req0_valid && req1_valid && (req0_ready || req1_ready))
        check_eq("rand_rr", 64'({req0_ready, req1_ready}), prio_m ? 64'(2'b01) : 64'(2'b10));
      if (req0_valid && req0_ready) begin
        q0.push_back(ref_alu(pa[0], pb[0], pop[0]));
        v[0] = 1'b0;
      end
      if (req1_valid && req1_ready) begin
        q1.push_back(ref_alu(pa[1], pb[1], pop[1]));
        v[1] = 1'b0;
      end
      if (rsp0_valid) begin
        check_eq("rand_gate1", 64'({rsp1_result, rsp1_flags}), 64'(0));
        if (rsp0_ready) begin
          if (q0.size() == 0) check_eq("rand_spurious0", 64'(1), 64'(0));
          else begin
            e = q0.pop_front();
            check_eq("rand_rsp0", 64'(rdata(1'b0)), 64'(e));
          end
          prio_m = 1'b1;
          done++;
        end
      end
      if (rsp1_valid) begin
        check_eq("rand_gate0", 64'({rsp0_result, rsp0_flags}), 64'(0));
        if (rsp1_ready) begin
          if (q1.size() == 0) check_eq("rand_spurious1", 64'(1), 64'(0));
          else begin
            e = q1.pop_front();
            check_eq("rand_rsp1", 64'(rdata(1'b1)), 64'(e));
          end
          prio_m = 1'b0;
          done++;
        end
      end
    end
    check_eq("rand_done", 64'(done), 64'(1000));
    check_eq("rand_drained", 64'(q0.size() + q1.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
